ocimem_access_arbiter: RTL
==========================

OCIMEM_ACCESS_ARBITER -- requirements
Module: ocimem_access_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width of the OCI debug RAM.
REQ-002 Parameter: DATA_W, default 32, data width of RAM and both requester ports.
REQ-003 Clocking and reset SHALL be as follows: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 debugack  in  1  CPU in debug mode; gives JTAG absolute priority.
REQ-007 jtag_req_valid / jtag_req_ready  in / out  1 / 1  JTAG-side (clk-domain) command handshake.
REQ-008 jtag_req_write  in  1  1 = write, 0 = read.
REQ-009 jtag_req_load  in  1  1 = use jtag_req_addr; 0 = use internal auto-increment pointer.
REQ-010 jtag_req_addr  in  ADDR_W  explicit word address.
REQ-011 jtag_req_wdata  in  DATA_W  write data; all bytes written.
REQ-012 jtag_rsp_valid / jtag_rsp_rdata  out  1 / DATA_W  one-cycle read-response pulse and data (MonDReg source).
REQ-013 avs_address, avs_read, avs_write, avs_writedata, avs_byteenable  in  ADDR_W,1,1,DATA_W,DATA_W/8  CPU Avalon-MM slave request.
REQ-014 avs_waitrequest  out  1  stall; request accepted in the cycle it is low.
REQ-015 avs_readdatavalid / avs_readdata  out  1 / DATA_W  read response.
REQ-016 ram_en, ram_wren, ram_addr, ram_byteen, ram_wdata  out  1,1,ADDR_W,DATA_W/8,DATA_W  RAM port.
REQ-017 ram_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after ram_en with ram_wren=0.
REQ-018 jtag_ptr  out  ADDR_W  current auto-increment pointer.

Function
REQ-019 FSM states SHALL be IDLE, RD_JTAG, RD_CPU; only IDLE grants.
REQ-020 In IDLE, grant SHALL go to JTAG if only JTAG requests, to CPU if only CPU (avs_read|avs_write) requests.
REQ-021 Both requesting, debugack=1: JTAG SHALL win.
REQ-022 Both requesting, debugack=0: requester not granted last SHALL win (round-robin); last_grant resets to CPU, so JTAG wins first tie.
REQ-023 Grant cycle: jtag_req_ready=1 (JTAG) or avs_waitrequest=0 (CPU), ram_en=1, ram_addr/ram_wren/ram_byteen/ram_wdata driven from winner; loser sees ready=0 / waitrequest=1.
REQ-024 avs_waitrequest SHALL be 1 whenever CPU not granted, including outside IDLE.
REQ-025 Granted write: single cycle, FSM stays IDLE, next grant possible next cycle; no response.
REQ-026 Granted read: FSM -> RD_JTAG/RD_CPU; next cycle captures ram_rdata into response register; cycle after that rsp_valid=1 for exactly one cycle, FSM back in IDLE (grant at cycle N, valid at N+2, next grant allowed at N+2).
REQ-027 JTAG effective address = jtag_req_addr if jtag_req_load else jtag_ptr; on every accepted JTAG access jtag_ptr <= effective address + 1 modulo 2^ADDR_W (255 wraps to 0).
REQ-028 CPU accesses SHALL NOT modify jtag_ptr.
REQ-029 avs_read and avs_write both high: treated as write; read ignored.
REQ-030 jtag_rsp_rdata / avs_readdata SHALL hold last value until next response.

Reset
REQ-031 While reset=1: FSM=IDLE, jtag_ptr=0, last_grant=CPU, response data=0, all outputs 0 except avs_waitrequest=1.
REQ-032 Reset during RD_JTAG/RD_CPU SHALL abort the read; no rsp_valid pulse after reset deasserts.

Verification
REQ-033 Reset, JTAG write load=1 addr 0x10 data 0xDEADBEEF, then CPU read 0x10 -> avs_readdatavalid 2 cycles after accept, avs_readdata=0xDEADBEEF.
REQ-034 JTAG reads load=1 addr 0xFE then two with load=0 -> addresses 0xFE,0xFF,0x00; jtag_ptr ends 0x01; three rsp pulses.
REQ-035 Continuous JTAG and CPU reads, debugack=0 -> grants alternate J,C,J,C; each requester served every 4 cycles.
REQ-036 Same with debugack=1 -> only JTAG granted; avs_waitrequest held 1 throughout.
REQ-037 CPU write byteenable 4'b0100 data 0x00AB0000 over 0x11223344 -> read back 0x11AB3344.
REQ-038 Reset asserted in RD_JTAG cycle -> no jtag_rsp_valid; jtag_ptr=0; first post-reset request granted immediately.

Source files
------------

// File: rtl/ocimem_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// ocimem_access_arbiter_if
//   Bundles every non-clock signal of the OCI debug RAM arbiter.
//   slave  : arbiter view (receives JTAG/CPU requests and RAM read data,
//            drives grants, responses and the RAM port).
//   master : requester/RAM view (the opposite directions).
//   Signal groups:
//     debugack                        CPU in debug mode, JTAG gets priority
//     jtag_req_* / jtag_rsp_*         JTAG-side command handshake and response
//     jtag_ptr                        auto-increment pointer
//     avs_*                           CPU Avalon-MM slave port
//     ram_*                           single-port RAM interface
// ---------------------------------------------------------------------------
interface ocimem_access_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic                  debugack;

   logic                  jtag_req_valid;
   logic                  jtag_req_ready;
   logic                  jtag_req_write;
   logic                  jtag_req_load;
   logic [ADDR_W-1:0]     jtag_req_addr;
   logic [DATA_W-1:0]     jtag_req_wdata;
   logic                  jtag_rsp_valid;
   logic [DATA_W-1:0]     jtag_rsp_rdata;
   logic [ADDR_W-1:0]     jtag_ptr;

   logic [ADDR_W-1:0]     avs_address;
   logic                  avs_read;
   logic                  avs_write;
   logic [DATA_W-1:0]     avs_writedata;
   logic [DATA_W/8-1:0]   avs_byteenable;
   logic                  avs_waitrequest;
   logic                  avs_readdatavalid;
   logic [DATA_W-1:0]     avs_readdata;

   logic                  ram_en;
   logic                  ram_wren;
   logic [ADDR_W-1:0]     ram_addr;
   logic [DATA_W/8-1:0]   ram_byteen;
   logic [DATA_W-1:0]     ram_wdata;
   logic [DATA_W-1:0]     ram_rdata;

   modport slave (
      input  debugack,
      input  jtag_req_valid, jtag_req_write, jtag_req_load,
      input  jtag_req_addr, jtag_req_wdata,
      output jtag_req_ready, jtag_rsp_valid, jtag_rsp_rdata, jtag_ptr,
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      output avs_waitrequest, avs_readdatavalid, avs_readdata,
      output ram_en, ram_wren, ram_addr, ram_byteen, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output debugack,
      output jtag_req_valid, jtag_req_write, jtag_req_load,
      output jtag_req_addr, jtag_req_wdata,
      input  jtag_req_ready, jtag_rsp_valid, jtag_rsp_rdata, jtag_ptr,
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      input  avs_waitrequest, avs_readdatavalid, avs_readdata,
      input  ram_en, ram_wren, ram_addr, ram_byteen, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/ocimem_access_arbiter.sv
// ---------------------------------------------------------------------------
// ocimem_access_arbiter
//   Shares one single-port OCI debug RAM between the JTAG debug path and the
//   CPU Avalon-MM slave.  Grants are issued only from IDLE; a write finishes
//   in the grant cycle, a read spends one cycle in RD_JTAG/RD_CPU capturing
//   RAM data and pulses the response valid in the following cycle.
//   Ports:
//     clk    rising-edge system clock
//     reset  synchronous, active-high reset
//     bus    ocimem_access_arbiter_if.slave (JTAG, Avalon, RAM, jtag_ptr)
// ---------------------------------------------------------------------------
module ocimem_access_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   ocimem_access_arbiter_if.slave   bus
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      RD_JTAG,
      RD_CPU
   } state_t;

   typedef enum logic {
      GNT_CPU,
      GNT_JTAG
   } grant_t;

   state_t              state_q, state_d;
   grant_t              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   jtag_ptr_q, jtag_ptr_d;
   logic [ADDR_W-1:0]   jtag_addr_eff;
   logic [DATA_W-1:0]   jtag_rdata_q;
   logic [DATA_W-1:0]   avs_rdata_q;
   logic                jtag_rsp_valid_q;
   logic                avs_rsp_valid_q;
   logic                cpu_req;
   logic                grant_jtag;
   logic                grant_cpu;

   // Arbitration and next-state logic
   always_comb begin
      jtag_addr_eff = bus.jtag_req_load ? bus.jtag_req_addr : jtag_ptr_q;
      cpu_req       = bus.avs_read | bus.avs_write;
      grant_jtag    = 1'b0;
      grant_cpu     = 1'b0;
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      jtag_ptr_d    = jtag_ptr_q;

      case (state_q)
         IDLE: begin
            // Grants are suppressed during reset so all outputs stay idle.
            if (!reset) begin
               if (bus.jtag_req_valid && cpu_req) begin
                  // Tie: debug mode forces JTAG, otherwise alternate.
                  if (bus.debugack || (last_grant_q == GNT_CPU)) begin
                     grant_jtag = 1'b1;
                  end else begin
                     grant_cpu = 1'b1;
                  end
               end else if (bus.jtag_req_valid) begin
                  grant_jtag = 1'b1;
               end else if (cpu_req) begin
                  grant_cpu = 1'b1;
               end
            end
         end
         RD_JTAG, RD_CPU: state_d = IDLE;
         default:         state_d = IDLE;
      endcase

      if (grant_jtag) begin
         last_grant_d = GNT_JTAG;
         jtag_ptr_d   = jtag_addr_eff + ADDR_W'(1);
         if (!bus.jtag_req_write) begin
            state_d = RD_JTAG;
         end
      end

      // avs_write wins over avs_read when both are asserted.
      if (grant_cpu) begin
         last_grant_d = GNT_CPU;
         if (!bus.avs_write) begin
            state_d = RD_CPU;
         end
      end
   end

   // RAM port mux driven from the winner of the current grant cycle
   always_comb begin
      bus.ram_en     = 1'b0;
      bus.ram_wren   = 1'b0;
      bus.ram_addr   = '0;
      bus.ram_byteen = '0;
      bus.ram_wdata  = '0;
      if (grant_jtag) begin
         bus.ram_en     = 1'b1;
         bus.ram_wren   = bus.jtag_req_write;
         bus.ram_addr   = jtag_addr_eff;
         bus.ram_byteen = {BE_W{1'b1}};
         bus.ram_wdata  = bus.jtag_req_wdata;
      end else if (grant_cpu) begin
         bus.ram_en     = 1'b1;
         bus.ram_wren   = bus.avs_write;
         bus.ram_addr   = bus.avs_address;
         bus.ram_byteen = bus.avs_byteenable;
         bus.ram_wdata  = bus.avs_writedata;
      end
   end

   always_comb begin
      bus.jtag_req_ready    = grant_jtag;
      bus.avs_waitrequest   = ~grant_cpu;
      bus.jtag_rsp_valid    = jtag_rsp_valid_q;
      bus.jtag_rsp_rdata    = jtag_rdata_q;
      bus.avs_readdatavalid = avs_rsp_valid_q;
      bus.avs_readdata      = avs_rdata_q;
      bus.jtag_ptr          = jtag_ptr_q;
   end

   // State, pointer and response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         last_grant_q     <= GNT_CPU;
         jtag_ptr_q       <= '0;
         jtag_rdata_q     <= '0;
         avs_rdata_q      <= '0;
         jtag_rsp_valid_q <= 1'b0;
         avs_rsp_valid_q  <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         jtag_ptr_q       <= jtag_ptr_d;
         // RAM data is valid in the RD cycle; the pulse follows one cycle later.
         jtag_rsp_valid_q <= (state_q == RD_JTAG);
         avs_rsp_valid_q  <= (state_q == RD_CPU);
         if (state_q == RD_JTAG) begin
            jtag_rdata_q <= bus.ram_rdata;
         end
         if (state_q == RD_CPU) begin
            avs_rdata_q <= bus.ram_rdata;
         end
      end
   end

endmodule
